// File: rtl/ast_tensor_job_sequencer.sv
// Job sequencer for the tensor unit: fetches A, B and optional bias W from word SRAM,
// pushes them into the unit, starts it, waits for done and drains X back to SRAM.
module ast_tensor_job_sequencer #(
    parameter int DATAWIDTH = 14,
    parameter int SIZE      = 4,
    parameter int ADDR_W    = 10,
    parameter int TIMEOUT   = 1024,
    localparam int DIM      = $clog2(SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [DIM-1:0]       cmd_a_dep,
    input  logic [DIM-1:0]       cmd_a_wid,
    input  logic [DIM-1:0]       cmd_b_dep,
    input  logic [DIM-1:0]       cmd_b_wid,
    input  logic                 cmd_relu,
    input  logic                 cmd_bias,
    input  logic [ADDR_W-1:0]    cmd_a_addr,
    input  logic [ADDR_W-1:0]    cmd_b_addr,
    input  logic [ADDR_W-1:0]    cmd_w_addr,
    input  logic [ADDR_W-1:0]    cmd_x_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_err,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [DATAWIDTH-1:0] mem_wdata,
    input  logic [DATAWIDTH-1:0] mem_rdata,
    output logic                 tu_wen,
    output logic [1:0]           tu_set,
    output logic [DIM-1:0]       tu_depth,
    output logic [DIM-1:0]       tu_width,
    output logic [DATAWIDTH-1:0] tu_data_in,
    output logic                 tu_start,
    output logic                 tu_ren,
    output logic                 tu_relu,
    output logic                 tu_clear,
    input  logic                 tu_busy,
    input  logic                 tu_done,
    input  logic [DATAWIDTH-1:0] tu_data_out
);
    localparam int NW    = 2 * DIM;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (TW > NW + 1) ? TW : NW + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_LOAD_A, S_LOAD_B, S_LOAD_W, S_START, S_WAIT, S_DRAIN, S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [DIM-1:0]     a_dep_q, a_dep_d, a_wid_q, a_wid_d, b_dep_q, b_dep_d, b_wid_q, b_wid_d;
    logic               relu_q, relu_d, bias_q, bias_d;
    logic [ADDR_W-1:0]  a_addr_q, a_addr_d, b_addr_q, b_addr_d, w_addr_q, w_addr_d, x_addr_q, x_addr_d;
    logic               push_vld_q, push_vld_d;
    logic [1:0]         push_set_q, push_set_d;
    logic [DIM-1:0]     push_dep_q, push_dep_d, push_wid_q, push_wid_d;

    logic [CNT_W-1:0]   n_a, n_b, n_w, ld_n;
    logic [ADDR_W-1:0]  ld_base;
    logic [1:0]         ld_set;
    logic [DIM-1:0]     ld_dep, ld_wid;
    logic               ld_last, ld_active, rd_en, ld_done, dims_bad, timeout_hit;
    logic               unused_busy;

    // Busy is informational only; completion is signalled solely by tu_done.
    assign unused_busy = tu_busy;

    assign n_a = CNT_W'(a_dep_q) * CNT_W'(a_wid_q);
    assign n_b = CNT_W'(b_dep_q) * CNT_W'(b_wid_q);
    assign n_w = CNT_W'(a_wid_q) * CNT_W'(b_dep_q);

    assign dims_bad = (a_dep_q == '0) || (a_wid_q == '0) || (b_dep_q == '0) || (b_wid_q == '0) ||
                      (a_dep_q > DIM'(SIZE)) || (a_wid_q > DIM'(SIZE)) ||
                      (b_dep_q > DIM'(SIZE)) || (b_wid_q > DIM'(SIZE)) || (a_dep_q != b_wid_q);

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        ld_n      = '0;
        ld_base   = '0;
        ld_set    = 2'd0;
        ld_dep    = '0;
        ld_wid    = '0;
        ld_last   = 1'b0;
        ld_active = 1'b1;
        case (state_q)
            S_LOAD_A: begin ld_n = n_a; ld_base = a_addr_q; ld_set = 2'd0; ld_dep = a_dep_q; ld_wid = a_wid_q; end
            S_LOAD_B: begin ld_n = n_b; ld_base = b_addr_q; ld_set = 2'd1; ld_dep = b_dep_q; ld_wid = b_wid_q;
                            ld_last = !bias_q; end
            S_LOAD_W: begin ld_n = n_w; ld_base = w_addr_q; ld_set = 2'd3; ld_dep = b_dep_q; ld_wid = a_wid_q;
                            ld_last = 1'b1; end
            default:  ld_active = 1'b0;
        endcase
    end

    // The final load set holds one extra cycle so its last push lands before tu_start.
    assign rd_en   = ld_active && (cnt_q < ld_n);
    assign ld_done = ld_last ? (cnt_q == ld_n) : (cnt_q == ld_n - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            push_vld_q <= 1'b0;
            push_set_q <= 2'd0;
            push_dep_q <= '0;
            push_wid_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            push_vld_q <= push_vld_d;
            push_set_q <= push_set_d;
            push_dep_q <= push_dep_d;
            push_wid_q <= push_wid_d;
        end
    end

    always_ff @(posedge clk) begin
        a_dep_q  <= a_dep_d;   a_wid_q  <= a_wid_d;
        b_dep_q  <= b_dep_d;   b_wid_q  <= b_wid_d;
        relu_q   <= relu_d;    bias_q   <= bias_d;
        a_addr_q <= a_addr_d;  b_addr_q <= b_addr_d;
        w_addr_q <= w_addr_d;  x_addr_q <= x_addr_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        a_dep_d  = a_dep_q;   a_wid_d  = a_wid_q;
        b_dep_d  = b_dep_q;   b_wid_d  = b_wid_q;
        relu_d   = relu_q;    bias_d   = bias_q;
        a_addr_d = a_addr_q;  b_addr_d = b_addr_q;
        w_addr_d = w_addr_q;  x_addr_d = x_addr_q;
        push_vld_d = rd_en;
        push_set_d = rd_en ? ld_set : push_set_q;
        push_dep_d = rd_en ? ld_dep : push_dep_q;
        push_wid_d = rd_en ? ld_wid : push_wid_q;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                a_dep_d  = cmd_a_dep;   a_wid_d  = cmd_a_wid;
                b_dep_d  = cmd_b_dep;   b_wid_d  = cmd_b_wid;
                relu_d   = cmd_relu;    bias_d   = cmd_bias;
                a_addr_d = cmd_a_addr;  b_addr_d = cmd_b_addr;
                w_addr_d = cmd_w_addr;  x_addr_d = cmd_x_addr;
                err_d    = 1'b0;
                cnt_d    = '0;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                cnt_d = '0;
                if (dims_bad) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A, S_LOAD_B, S_LOAD_W: begin
                if (ld_done) begin
                    cnt_d = '0;
                    if (state_q == S_LOAD_A)     state_d = S_LOAD_B;
                    else if (ld_last)            state_d = S_START;
                    else                         state_d = S_LOAD_W;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tu_done) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == n_w - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        mem_rd     = rd_en;
        mem_wr     = 1'b0;
        mem_addr   = rd_en ? ld_base + ADDR_W'(cnt_q) : '0;
        mem_wdata  = '0;
        tu_wen     = push_vld_q;
        tu_set     = push_set_q;
        tu_depth   = push_dep_q;
        tu_width   = push_wid_q;
        tu_data_in = push_vld_q ? mem_rdata : '0;
        tu_start   = 1'b0;
        tu_ren     = 1'b0;
        tu_relu    = 1'b0;
        tu_clear   = 1'b0;
        case (state_q)
            S_START: begin tu_start = 1'b1; tu_relu = relu_q; end
            S_WAIT: begin
                tu_relu  = relu_q;
                tu_clear = timeout_hit && !tu_done;
            end
            S_DRAIN: begin
                tu_relu   = relu_q;
                tu_ren    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = x_addr_q + ADDR_W'(cnt_q);
                mem_wdata = tu_data_out;
            end
            S_RESP: begin rsp_valid = 1'b1; rsp_err = err_q; end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ast_tensor_job_sequencer.sv
// Directed bench: SRAM and tensor-unit models around the sequencer, checking
// fetch order, push tagging, results written back, error/timeout/reset handling.
module tb_ast_tensor_job_sequencer;
    logic        clk, reset;
    logic        cmd_valid, cmd_ready, cmd_relu, cmd_bias;
    logic [2:0]  cmd_a_dep, cmd_a_wid, cmd_b_dep, cmd_b_wid;
    logic [9:0]  cmd_a_addr, cmd_b_addr, cmd_w_addr, cmd_x_addr;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [9:0]  mem_addr;
    logic        mem_rd, mem_wr;
    logic [13:0] mem_wdata, mem_rdata;
    logic        tu_wen, tu_start, tu_ren, tu_relu, tu_clear, tu_busy, tu_done;
    logic [1:0]  tu_set;
    logic [2:0]  tu_depth, tu_width;
    logic [13:0] tu_data_in, tu_data_out;

    ast_tensor_job_sequencer #(.DATAWIDTH(14), .SIZE(4), .ADDR_W(10), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a_dep(cmd_a_dep), .cmd_a_wid(cmd_a_wid), .cmd_b_dep(cmd_b_dep), .cmd_b_wid(cmd_b_wid),
        .cmd_relu(cmd_relu), .cmd_bias(cmd_bias), .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr),
        .cmd_w_addr(cmd_w_addr), .cmd_x_addr(cmd_x_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .tu_wen(tu_wen), .tu_set(tu_set), .tu_depth(tu_depth), .tu_width(tu_width),
        .tu_data_in(tu_data_in), .tu_start(tu_start), .tu_ren(tu_ren), .tu_relu(tu_relu),
        .tu_clear(tu_clear), .tu_busy(tu_busy), .tu_done(tu_done), .tu_data_out(tu_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // SRAM model with a preload port
    logic [13:0] sram [1024];
    logic        pl_we;
    logic [9:0]  pl_addr;
    logic [13:0] pl_data;
    always @(posedge clk) begin
        if (pl_we) sram[pl_addr] <= pl_data;
        else if (mem_wr) sram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= sram[mem_addr];
    end

    // Tensor unit model: X[r][c] = sum_k A[r*ad+k]*B[k*bd+c] (+ W[r*bd+c]), optional ReLU
    int          a_m [16];
    int          b_m [16];
    int          w_m [16];
    logic [13:0] x_m [16];
    int          na_m, nb_m, nw_m, ad_m, aw_m, bd_m, cd_m;
    logic        busy_m;
    logic [4:0]  rd_idx;
    bit          never_done;
    assign tu_busy     = busy_m;
    assign tu_data_out = x_m[rd_idx[3:0]];

    function automatic logic [13:0] calc(input int r, input int c);
        int acc;
        acc = 0;
        for (int k = 0; k < ad_m; k++) acc += a_m[(r * ad_m + k) % 16] * b_m[(k * bd_m + c) % 16];
        if (nw_m > 0) acc += w_m[(r * bd_m + c) % 16];
        if (tu_relu && acc < 0) acc = 0;
        return 14'(acc);
    endfunction

    always @(posedge clk) begin
        tu_done <= 1'b0;
        if (reset || tu_clear) begin
            na_m <= 0; nb_m <= 0; nw_m <= 0; busy_m <= 1'b0; rd_idx <= '0; cd_m <= 0;
        end else begin
            if (tu_wen) begin
                case (tu_set)
                    2'd0: begin a_m[na_m % 16] <= int'($signed(tu_data_in)); na_m <= na_m + 1;
                                ad_m <= int'(tu_depth); aw_m <= int'(tu_width); end
                    2'd1: begin b_m[nb_m % 16] <= int'($signed(tu_data_in)); nb_m <= nb_m + 1;
                                bd_m <= int'(tu_depth); end
                    2'd3: begin w_m[nw_m % 16] <= int'($signed(tu_data_in)); nw_m <= nw_m + 1; end
                    default: ;
                endcase
            end
            if (tu_start) begin
                for (int r = 0; r < aw_m; r++)
                    for (int c = 0; c < bd_m; c++) x_m[(r * bd_m + c) % 16] <= calc(r, c);
                busy_m <= 1'b1; cd_m <= 6; rd_idx <= '0;
                na_m <= 0; nb_m <= 0; nw_m <= 0;
            end else if (busy_m && !never_done) begin
                if (cd_m == 1) begin tu_done <= 1'b1; busy_m <= 1'b0; end
                cd_m <= cd_m - 1;
            end
            if (tu_ren) rd_idx <= rd_idx + 5'd1;
        end
    end

    // Activity monitor, sampled on the falling edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_rd, n_wr, n_ren, n_start, n_clear, n_dimbad, n_overlap, n_badwr, start_cyc, clear_cyc;
    int n_push [4];
    int rd_addrs [$];
    int j_ad, j_aw, j_bd, j_bw, j_aa, j_ba, j_wa, j_xa;
    always @(negedge clk) begin
        if (mem_rd) begin n_rd++; rd_addrs.push_back(int'(mem_addr)); end
        if (mem_rd && mem_wr) n_overlap++;
        if (mem_wr) begin n_wr++; if (!tu_ren) n_badwr++; end
        if (tu_ren) n_ren++;
        if (tu_start) begin n_start++; start_cyc = cyc; end
        if (tu_clear) begin n_clear++; clear_cyc = cyc; end
        if (tu_wen) begin
            n_push[tu_set]++;
            case (tu_set)
                2'd0: if (int'(tu_depth) != j_ad || int'(tu_width) != j_aw) n_dimbad++;
                2'd1: if (int'(tu_depth) != j_bd || int'(tu_width) != j_bw) n_dimbad++;
                2'd3: if (int'(tu_depth) != j_bd || int'(tu_width) != j_aw) n_dimbad++;
                default: n_dimbad++;
            endcase
        end
    end

    logic [63:0] outs;
    assign outs = 64'({mem_rd, mem_wr, mem_addr, mem_wdata, tu_wen, tu_set, tu_depth, tu_width,
                       tu_data_in, tu_start, tu_ren, tu_relu, tu_clear, rsp_valid, rsp_err});

    task automatic pl(input int addr, input int v);
        pl_we = 1'b1; pl_addr = 10'(addr); pl_data = 14'(v);
        @(negedge clk);
    endtask

    task automatic send_cmd(input int ad, aw, bd, bw, input bit relu, bias, input int aa, ba, wa, xa);
        @(negedge clk);
        j_ad = ad; j_aw = aw; j_bd = bd; j_bw = bw; j_aa = aa; j_ba = ba; j_wa = wa; j_xa = xa;
        n_rd = 0; n_wr = 0; n_ren = 0; n_start = 0; n_clear = 0; n_dimbad = 0; n_overlap = 0; n_badwr = 0;
        for (int i = 0; i < 4; i++) n_push[i] = 0;
        rd_addrs.delete();
        check_eq("cmd_ready_idle", cmd_ready, 1);
        cmd_a_dep = 3'(ad); cmd_a_wid = 3'(aw); cmd_b_dep = 3'(bd); cmd_b_wid = 3'(bw);
        cmd_relu = relu; cmd_bias = bias;
        cmd_a_addr = 10'(aa); cmd_b_addr = 10'(ba); cmd_w_addr = 10'(wa); cmd_x_addr = 10'(xa);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("cmd_ready_drop", cmd_ready, 0);
    endtask

    task automatic wait_rsp(input bit hold, output logic err);
        int k, st;
        k = 0;
        while (!rsp_valid && k < 3000) begin @(negedge clk); k++; end
        check_eq("rsp_seen", rsp_valid, 1);
        err = rsp_err;
        if (hold) begin
            st = 0;
            repeat (10) begin @(negedge clk); if (rsp_valid && !cmd_ready) st++; end
            check_eq("rsp_stall", st, 10);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_drop", rsp_valid, 0);
        check_eq("cmd_ready_back", cmd_ready, 1);
    endtask

    task automatic check_ok(input string nm, input logic err, input int nw, input int e0, e1, e2, e3);
        int na, nb, ea, ga;
        int ex [4];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        na = j_ad * j_aw; nb = j_bd * j_bw;
        check_eq({nm, "_err"}, err, 0);
        check_eq({nm, "_nrd"}, n_rd, na + nb + nw);
        for (int i = 0; i < na + nb + nw; i++) begin
            ea = (i < na) ? j_aa + i : (i < na + nb) ? j_ba + i - na : j_wa + i - na - nb;
            ga = (i < rd_addrs.size()) ? rd_addrs[i] : -1;
            check_eq({nm, "_rdaddr"}, ga, ea % 1024);
        end
        check_eq({nm, "_push_a"}, n_push[0], na);
        check_eq({nm, "_push_b"}, n_push[1], nb);
        check_eq({nm, "_push_w"}, n_push[3], nw);
        check_eq({nm, "_dims"}, n_dimbad, 0);
        check_eq({nm, "_starts"}, n_start, 1);
        check_eq({nm, "_nwr"}, n_wr, 4);
        check_eq({nm, "_nren"}, n_ren, 4);
        check_eq({nm, "_wr_ren"}, n_badwr, 0);
        check_eq({nm, "_overlap"}, n_overlap, 0);
        for (int i = 0; i < 4; i++) check_eq({nm, "_x"}, sram[(j_xa + i) % 1024], 14'(ex[i]));
    endtask

    task automatic check_rej(input string nm, input logic err);
        check_eq({nm, "_err"}, err, 1);
        check_eq({nm, "_nrd"}, n_rd, 0);
        check_eq({nm, "_nwen"}, n_push[0] + n_push[1] + n_push[2] + n_push[3], 0);
        check_eq({nm, "_starts"}, n_start, 0);
        check_eq({nm, "_nwr"}, n_wr, 0);
    endtask

    initial begin
        logic err;
        int   k, hits;
        bit   found;
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        never_done = 1'b0;
        cmd_a_dep = '0; cmd_a_wid = '0; cmd_b_dep = '0; cmd_b_wid = '0; cmd_relu = 1'b0; cmd_bias = 1'b0;
        cmd_a_addr = '0; cmd_b_addr = '0; cmd_w_addr = '0; cmd_x_addr = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", outs, 0);
        check_eq("reset_cmd_ready", cmd_ready, 1);

        // A1 = [[1,2,3],[4,5,6]], B = [[1,0],[0,1],[1,1]], W = 5s, A2 = [[-1,2,-3],[4,-5,6]]
        for (int i = 0; i < 6; i++) pl(100 + i, i + 1);
        pl(200, 1); pl(201, 0); pl(202, 0); pl(203, 1); pl(204, 1); pl(205, 1);
        for (int i = 0; i < 4; i++) pl(300 + i, 5);
        pl(120, -1); pl(121, 2); pl(122, -3); pl(123, 4); pl(124, -5); pl(125, 6);
        pl_we = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Plain job, with the response held off for ten cycles
        send_cmd(3, 2, 2, 3, 0, 0, 100, 200, 300, 400);
        wait_rsp(1, err);
        check_ok("plain", err, 0, 4, 5, 10, 11);

        send_cmd(3, 2, 2, 3, 0, 1, 100, 200, 300, 410);
        wait_rsp(0, err);
        check_ok("bias", err, 4, 9, 10, 15, 16);

        // ReLU with negative products; X wraps past the top of the address space
        send_cmd(3, 2, 2, 3, 1, 0, 120, 200, 300, 1022);
        wait_rsp(0, err);
        check_ok("relu", err, 0, 0, 0, 10, 1);

        send_cmd(0, 2, 2, 0, 0, 0, 100, 200, 300, 440);
        wait_rsp(0, err);
        check_rej("dim_zero", err);
        send_cmd(5, 2, 2, 5, 0, 0, 100, 200, 300, 440);
        wait_rsp(0, err);
        check_rej("dim_big", err);
        send_cmd(3, 2, 2, 2, 0, 1, 100, 200, 300, 440);
        wait_rsp(0, err);
        check_rej("dim_mismatch", err);

        never_done = 1'b1;
        send_cmd(3, 2, 2, 3, 0, 0, 100, 200, 300, 430);
        wait_rsp(0, err);
        check_eq("timeout_err", err, 1);
        check_eq("timeout_clear", n_clear, 1);
        check_eq("timeout_gap", clear_cyc - start_cyc, 64);
        check_eq("timeout_nwr", n_wr, 0);
        never_done = 1'b0;

        // Reset while B is being fetched
        send_cmd(3, 2, 2, 3, 0, 0, 100, 200, 300, 450);
        found = 1'b0; k = 0;
        while (!found && k < 200) begin
            if (mem_rd && mem_addr == 10'd200) found = 1'b1;
            else begin @(negedge clk); k++; end
        end
        check_eq("reach_load_b", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midreset_outs", outs, 0);
        check_eq("midreset_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        hits = 0;
        repeat (20) begin @(negedge clk); if (rsp_valid) hits++; end
        check_eq("midreset_no_rsp", hits, 0);
        check_eq("midreset_no_start", n_start, 0);

        send_cmd(3, 2, 2, 3, 0, 0, 100, 200, 300, 460);
        wait_rsp(0, err);
        check_ok("after_reset", err, 0, 4, 5, 10, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
